// File: rtl/tally_btn_ctrl.sv
// Purpose: debounced push-button sequencer that owns the 0..15 tally count and drives the LED thermometer.
// Latency: inc_pulse follows a stable press by DEB_CYC+3 edges; cnt/led follow inc_pulse by one edge.
// Backpressure: none; BTN/CLR are sampled every cycle and tick/inc_pulse are fire-and-forget strobes.
// Optional feature: define TALLY_AUTOREPEAT_EN to auto-repeat increments on each tick while the button is held.
module tally_btn_ctrl #(
   parameter int PRE_W   = 25,
   parameter int DEB_CYC = 1000000,
   parameter int REP_DLY = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        BTN,
   input  logic        CLR,
   output logic        tick,
   output logic        inc_pulse,
   output logic [3:0]  cnt,
   output logic [14:0] led
);

   // Debounce counter only ever needs to reach DEB_CYC-1.
   localparam int DEB_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYC - 1);

   // Elaboration-time guard on parameter ranges the FSM relies on.
   if (DEB_CYC < 2 || REP_DLY < 1) begin : g_param_chk
      $error("tally_btn_ctrl: DEB_CYC must be >= 2 and REP_DLY must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } deb_state_e;

   logic             sync1_q;
   logic             b_s_q;
   logic [PRE_W-1:0] pre_q;
   logic             tick_q;
   deb_state_e       state_q, state_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic             inc_q, inc_d;
   logic [3:0]       cnt_q, cnt_d;

`ifdef TALLY_AUTOREPEAT_EN
   // Repeat counter saturates at REP_DLY; at least 2 bits wide.
   localparam int REP_W = ($clog2(REP_DLY + 1) < 2) ? 2 : $clog2(REP_DLY + 1);
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_DLY);
   logic [REP_W-1:0] rep_q, rep_d;
`endif

   // Two-flop synchronizer for the raw, bouncing button.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 1'b0;
         b_s_q   <= 1'b0;
      end else begin
         sync1_q <= BTN;
         b_s_q   <= sync1_q;
      end
   end

   // Free-running prescaler; tick is registered while the prescaler sits at all ones.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_q + 1'b1;
         tick_q <= (pre_q == '1);
      end
   end

   // Debounce FSM next-state: press/release qualification, one-shot and optional auto-repeat.
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      inc_d   = 1'b0;
`ifdef TALLY_AUTOREPEAT_EN
      rep_d   = rep_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (b_s_q) begin
               state_d = PRESS_WAIT;
               deb_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!b_s_q) begin
               // Glitch shorter than the debounce window: abandon the press.
               state_d = IDLE;
               deb_d   = '0;
            end else if (deb_q == DEB_MAX) begin
               state_d = HELD;
               deb_d   = '0;
               inc_d   = 1'b1;
`ifdef TALLY_AUTOREPEAT_EN
               // Fresh press: repeat delay starts from zero.
               rep_d   = '0;
`endif
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         HELD: begin
            if (!b_s_q) begin
               state_d = REL_WAIT;
               deb_d   = '0;
            end
`ifdef TALLY_AUTOREPEAT_EN
            else if (tick_q) begin
               // Count ticks until the delay is met, then fire once per tick.
               if (rep_q >= REP_MAX) begin
                  inc_d = 1'b1;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
`endif
         end
         REL_WAIT: begin
            if (b_s_q) begin
               // Release bounce: back to HELD without a new increment; repeat counter kept.
               state_d = HELD;
               deb_d   = '0;
            end else if (deb_q == DEB_MAX) begin
               state_d = IDLE;
               deb_d   = '0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            deb_d   = '0;
         end
      endcase
   end

   // Debounce FSM state, debounce counter and registered increment strobe.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         deb_q   <= '0;
         inc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         inc_q   <= inc_d;
      end
   end

`ifdef TALLY_AUTOREPEAT_EN
   // Auto-repeat tick counter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end
`endif

   // Count next-state: clear has priority and swallows a coincident increment.
   always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
         cnt_d = 4'd0;
      end else if (inc_q) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Tally count register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Thermometer decode of the registered count: led[i] lit when i < cnt.
   always_comb begin
      led = '0;
      for (int i = 0; i < 15; i++) begin
         led[i] = (4'(i) < cnt_q);
      end
   end

   assign tick      = tick_q;
   assign inc_pulse = inc_q;
   assign cnt       = cnt_q;

endmodule

// File: tb/tb_tally_btn_ctrl.sv
// Purpose: directed self-checking bench for tally_btn_ctrl with PRE_W=4, DEB_CYC=8, REP_DLY=2.
// Latency: expected edges are hand-derived (press accepted after edge 11, first tick after edge 16).
// Backpressure: none; stimulus driven on falling edges, outputs sampled on falling edges or #1 after rising.
module tb_tally_btn_ctrl;

   localparam int PRE_W   = 4;
   localparam int DEB_CYC = 8;
   localparam int REP_DLY = 2;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        BTN;
   logic        CLR;
   logic        tick;
   logic        inc_pulse;
   logic [3:0]  cnt;
   logic [14:0] led;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   pulse_cnt    = 0;
   int   consec_cnt   = 0;
   logic prev_inc     = 1'b0;

   always #5 CLK = ~CLK;

   tally_btn_ctrl #(
      .PRE_W   (PRE_W),
      .DEB_CYC (DEB_CYC),
      .REP_DLY (REP_DLY)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .BTN       (BTN),
      .CLR       (CLR),
      .tick      (tick),
      .inc_pulse (inc_pulse),
      .cnt       (cnt),
      .led       (led)
   );

   // Count increment strobes and catch any two back-to-back.
   always @(negedge CLK) begin
      if (inc_pulse === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         if (prev_inc === 1'b1) consec_cnt = consec_cnt + 1;
      end
      prev_inc = inc_pulse;
   end

   // Reset with BTN low; returns on a falling edge with RST_N just released (next rise is edge 1).
   task automatic do_reset();
      @(negedge CLK);
      BTN   = 1'b0;
      CLR   = 1'b0;
      RST_N = 1'b0;
      #1 pulse_cnt = 0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   // Clean press: hold high for hi cycles then low for lo cycles (called on a falling edge).
   task automatic press(input int hi, input int lo);
      BTN = 1'b1;
      repeat (hi) @(negedge CLK);
      BTN = 1'b0;
      repeat (lo) @(negedge CLK);
   endtask

   task automatic test_reset();
      int          first_inc;
      int          first_tick;
      int          ticks;
      logic [3:0]  cnt12;
      logic [14:0] led12;
      @(negedge CLK);
      RST_N = 1'b0;
      BTN   = 1'b1;
      CLR   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         tests_run++;
         if (cnt !== 4'd0 || led !== 15'd0 || inc_pulse !== 1'b0 || tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold cyc%0d: cnt=%0d led=%h inc=%b tick=%b, want all zero",
                     i, cnt, led, inc_pulse, tick);
         end
      end
      RST_N      = 1'b1;
      first_inc  = 0;
      first_tick = 0;
      ticks      = 0;
      cnt12      = 4'd0;
      led12      = 15'd0;
      for (int e = 1; e <= 50; e++) begin
         @(posedge CLK);
         #1;
         if (inc_pulse === 1'b1 && first_inc == 0) first_inc = e;
         if (tick === 1'b1) begin
            ticks++;
            if (first_tick == 0) first_tick = e;
         end
         if (e == 12) begin
            cnt12 = cnt;
            led12 = led;
         end
      end
      tests_run++;
      if (first_inc !== 11) begin
         tests_failed++;
         $display("FAIL reset_first_inc: edge %0d, want 11", first_inc);
      end
      tests_run++;
      if (first_tick !== 16) begin
         tests_failed++;
         $display("FAIL reset_first_tick: edge %0d, want 16", first_tick);
      end
      tests_run++;
      if (ticks !== 3) begin
         tests_failed++;
         $display("FAIL tick_count_50: %0d ticks, want 3", ticks);
      end
      tests_run++;
      if (cnt12 !== 4'd1) begin
         tests_failed++;
         $display("FAIL reset_cnt_edge12: cnt=%0d, want 1", cnt12);
      end
      tests_run++;
      if (led12 !== 15'h0001) begin
         tests_failed++;
         $display("FAIL reset_led_edge12: led=%h, want 0001", led12);
      end
      @(negedge CLK);
      BTN = 1'b0;
      repeat (30) @(negedge CLK);
   endtask

   task automatic test_clean_press();
      do_reset();
      press(40, 40);
      tests_run++;
      if (pulse_cnt !== 1) begin
         tests_failed++;
         $display("FAIL clean_pulses: %0d, want 1", pulse_cnt);
      end
      tests_run++;
      if (cnt !== 4'd1) begin
         tests_failed++;
         $display("FAIL clean_cnt: %0d, want 1", cnt);
      end
      tests_run++;
      if (led !== 15'h0001) begin
         tests_failed++;
         $display("FAIL clean_led: %h, want 0001", led);
      end
   endtask

   task automatic test_bounce();
      // Press bounce: 3-cycle toggles never survive the 8-cycle window.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         BTN = 1'b1;
         repeat (3) @(negedge CLK);
         BTN = 1'b0;
         repeat (3) @(negedge CLK);
      end
      repeat (30) @(negedge CLK);
      tests_run++;
      if (pulse_cnt !== 0) begin
         tests_failed++;
         $display("FAIL bounce_pulses: %0d, want 0", pulse_cnt);
      end
      tests_run++;
      if (cnt !== 4'd0 || led !== 15'd0) begin
         tests_failed++;
         $display("FAIL bounce_cnt: cnt=%0d led=%h, want 0/0000", cnt, led);
      end
      // Release bounce after an accepted press: only the original increment.
      do_reset();
      BTN = 1'b1;
      repeat (15) @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
         BTN = 1'b0;
         repeat (3) @(negedge CLK);
         BTN = 1'b1;
         repeat (3) @(negedge CLK);
      end
      BTN = 1'b0;
      repeat (30) @(negedge CLK);
      tests_run++;
      if (pulse_cnt !== 1) begin
         tests_failed++;
         $display("FAIL release_bounce_pulses: %0d, want 1", pulse_cnt);
      end
      tests_run++;
      if (cnt !== 4'd1) begin
         tests_failed++;
         $display("FAIL release_bounce_cnt: %0d, want 1", cnt);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 15; i++) press(20, 20);
      tests_run++;
      if (cnt !== 4'd15) begin
         tests_failed++;
         $display("FAIL wrap_cnt15: %0d, want 15", cnt);
      end
      tests_run++;
      if (led !== 15'h7FFF) begin
         tests_failed++;
         $display("FAIL wrap_led15: %h, want 7fff", led);
      end
      press(20, 20);
      tests_run++;
      if (cnt !== 4'd0) begin
         tests_failed++;
         $display("FAIL wrap_cnt0: %0d, want 0", cnt);
      end
      tests_run++;
      if (led !== 15'd0) begin
         tests_failed++;
         $display("FAIL wrap_led0: %h, want 0000", led);
      end
      tests_run++;
      if (pulse_cnt !== 16) begin
         tests_failed++;
         $display("FAIL wrap_pulses: %0d, want 16", pulse_cnt);
      end
   endtask

   task automatic test_clear_collision();
      int waited;
      do_reset();
      for (int i = 0; i < 5; i++) press(20, 20);
      tests_run++;
      if (cnt !== 4'd5) begin
         tests_failed++;
         $display("FAIL clr_pre_cnt: %0d, want 5", cnt);
      end
      BTN    = 1'b1;
      waited = 0;
      while (inc_pulse !== 1'b1 && waited < 40) begin
         @(negedge CLK);
         waited++;
      end
      tests_run++;
      if (inc_pulse !== 1'b1) begin
         tests_failed++;
         $display("FAIL clr_wait_inc: inc_pulse=%b after %0d cycles, want 1", inc_pulse, waited);
      end
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
      tests_run++;
      if (cnt !== 4'd0 || led !== 15'd0) begin
         tests_failed++;
         $display("FAIL clr_collision: cnt=%0d led=%h, want 0/0000", cnt, led);
      end
      BTN = 1'b0;
      repeat (30) @(negedge CLK);
      tests_run++;
      if (cnt !== 4'd0) begin
         tests_failed++;
         $display("FAIL clr_discard: cnt=%0d, want 0", cnt);
      end
   endtask

   task automatic test_autorepeat();
      int          exp_pulses;
      logic [3:0]  exp_cnt;
      logic [14:0] exp_led;
`ifdef TALLY_AUTOREPEAT_EN
      // Press at edge 11, then repeats on ticks 3..12 in HELD (edges 49..193).
      exp_pulses = 11;
      exp_cnt    = 4'd11;
      exp_led    = 15'h07FF;
`else
      exp_pulses = 1;
      exp_cnt    = 4'd1;
      exp_led    = 15'h0001;
`endif
      do_reset();
      press(200, 40);
      tests_run++;
      if (pulse_cnt !== exp_pulses) begin
         tests_failed++;
         $display("FAIL autorep_pulses: %0d, want %0d", pulse_cnt, exp_pulses);
      end
      tests_run++;
      if (cnt !== exp_cnt) begin
         tests_failed++;
         $display("FAIL autorep_cnt: %0d, want %0d", cnt, exp_cnt);
      end
      tests_run++;
      if (led !== exp_led) begin
         tests_failed++;
         $display("FAIL autorep_led: %h, want %h", led, exp_led);
      end
   endtask

   task automatic test_midreset();
      int first_inc;
      do_reset();
      for (int i = 0; i < 7; i++) press(20, 20);
      tests_run++;
      if (cnt !== 4'd7) begin
         tests_failed++;
         $display("FAIL mid_pre_cnt: %0d, want 7", cnt);
      end
      BTN = 1'b1;
      repeat (6) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      tests_run++;
      if (cnt !== 4'd0 || led !== 15'd0 || inc_pulse !== 1'b0 || tick !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_async_clear: cnt=%0d led=%h inc=%b tick=%b, want all zero",
                  cnt, led, inc_pulse, tick);
      end
      repeat (3) @(negedge CLK);
      RST_N     = 1'b1;
      first_inc = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge CLK);
         #1;
         if (inc_pulse === 1'b1 && first_inc == 0) first_inc = e;
      end
      tests_run++;
      if (first_inc !== 11) begin
         tests_failed++;
         $display("FAIL mid_first_inc: edge %0d, want 11", first_inc);
      end
      @(negedge CLK);
      BTN = 1'b0;
      repeat (30) @(negedge CLK);
      tests_run++;
      if (cnt !== 4'd1) begin
         tests_failed++;
         $display("FAIL mid_post_cnt: %0d, want 1", cnt);
      end
   endtask

   task automatic test_no_back_to_back();
      tests_run++;
      if (consec_cnt !== 0) begin
         tests_failed++;
         $display("FAIL back_to_back: %0d consecutive inc_pulse cycles, want 0", consec_cnt);
      end
   endtask

   initial begin
      RST_N = 1'b0;
      BTN   = 1'b0;
      CLR   = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_wrap();
      test_clear_collision();
      test_autorepeat();
      test_midreset();
      test_no_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tally_btn_ctrl.md
# tally_btn_ctrl

Sequencing controller for the lab 8 stone-age tally counter: debounces the raw push-button, generates single-cycle increment commands, and owns the tally count. It drives the 15-LED thermometer and the 4-bit binary value to the seven-segment driver. It replaces the divided-clock arrangement with a clock-enable scheme, so all logic runs on the 100 MHz board clock.

## Interface
Parameters:
- PRE_W, 25: prescaler width; `tick` period is 2^PRE_W cycles.
- DEB_CYC, 1000000: stable cycles required to accept a press or release (>= 2).
- REP_DLY, 2: ticks the button must stay held before auto-repeat starts (>= 1).

Ports:
- CLK  in  1  board clock, all logic rising-edge.
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
- BTN  in  1  raw, asynchronous, bouncing push-button.
- CLR  in  1  synchronous clear of the count, level-sampled each cycle.
- tick  out  1  one-cycle strobe when the prescaler is all ones.
- inc_pulse  out  1  registered one-cycle increment command.
- cnt  out  4  binary count, 0..15.
- led  out  15  thermometer: led[i] = (i < cnt).

## Operation
- BTN passes through a 2-flop synchronizer; b_s is the second flop.
- Prescaler is a free-running PRE_W-bit up counter that wraps. `tick` is registered high for the cycle in which the prescaler equals all ones.
- Debounce FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT. A single deb counter is cleared on every state change.
  - IDLE: b_s=1 goes to PRESS_WAIT.
  - PRESS_WAIT: b_s=0 returns to IDLE. Otherwise deb increments. When deb==DEB_CYC-1 and b_s=1, go to HELD and assert inc_pulse.
  - HELD: b_s=0 goes to REL_WAIT. Auto-repeat runs here (see Configuration).
  - REL_WAIT: b_s=1 returns to HELD with no new increment. Otherwise deb increments. When deb==DEB_CYC-1, go to IDLE.
- Count update, evaluated on each edge:
  - CLR=1: cnt goes to 0. CLR wins over a simultaneous inc_pulse, and that increment is discarded.
  - inc_pulse=1: cnt goes to cnt+1 mod 16, so 15 wraps to 0 and led goes all off.
- led is derived from the registered cnt and changes in the same cycle as cnt.
- When RST_N is asserted mid-operation (any state, any counter value), everything clears immediately. This includes the synchronizer, prescaler, deb, the repeat counter, state (IDLE), cnt, led, tick and inc_pulse.

## Timing
- Reset values: tick=0, inc_pulse=0, cnt=0, led=0, state IDLE.
- Press latency: BTN rises before edge 1 and stays stable. inc_pulse is high for exactly one cycle after edge DEB_CYC+3. cnt and led update at edge DEB_CYC+4.
- A BTN glitch shorter than DEB_CYC cycles in IDLE produces no inc_pulse.
- Release bounce shorter than DEB_CYC in REL_WAIT produces no inc_pulse.
- inc_pulse is never high on two consecutive cycles.
- tick is high for 1 of every 2^PRE_W cycles. The first tick is high after edge 2^PRE_W following reset release.

## Configuration
- TALLY_AUTOREPEAT_EN defined:
  - In HELD, a 2-bit+ repeat counter is cleared on entry to HELD and counts ticks.
  - Once the counter has reached REP_DLY, each subsequent tick while still in HELD asserts inc_pulse for that cycle.
  - REL_WAIT freezes the repeat counter. Returning to HELD from REL_WAIT resumes the counter without clearing it.
- TALLY_AUTOREPEAT_EN undefined:
  - There is no repeat counter, and exactly one increment occurs per accepted press.

## Test plan
All scenarios use PRE_W=4, DEB_CYC=8, REP_DLY=2.
- Reset: hold RST_N=0 with BTN=1 -> cnt=0, led=0, inc_pulse=0 throughout. Release -> first inc_pulse after edge 11.
- Clean press: BTN high 40 cycles, then low 40 cycles -> exactly one inc_pulse. cnt goes 0 to 1, led=15'h0001.
- Bounce: BTN toggles every 3 cycles for 30 cycles, then stays low -> no inc_pulse, cnt stays 0.
- Wrap and clear:
  - 16 clean presses -> cnt 15 (led=15'h7FFF), then 0 (led=0).
  - CLR asserted on the same cycle as an inc_pulse with cnt=5 -> cnt=0.
- Auto-repeat: with the macro defined, hold BTN 200 cycles -> one press increment, then one increment per tick starting from the 3rd tick in HELD. Without the macro -> exactly one increment.
- Mid-operation reset: assert RST_N=0 while in PRESS_WAIT with cnt=7 -> cnt=0 and state IDLE immediately, with no inc_pulse after release while BTN is still high until DEB_CYC+3 edges have elapsed.
